// File: rtl/task_answer_arbiter.sv
// Round-robin arbiter that shares the task-manager answer port between
// N_REQ answer buffers. One packet is forwarded at a time. Packet length
// is checked against the advertised size, and a watchdog aborts a packet
// that stalls for too long. Error pulses are registered, so each pulse
// appears in the cycle after the event that caused it.
module task_answer_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_REQ-1:0]    i_req_ready,
  input  logic [8*N_REQ-1:0]  i_req_data,
  input  logic [N_REQ-1:0]    i_req_last,
  input  logic [12*N_REQ-1:0] i_req_size,
  output logic [N_REQ-1:0]    o_req_mgr_ready,
  input  logic                i_mgr_ready,
  output logic                o_mgr_valid,
  output logic [7:0]          o_mgr_data,
  output logic                o_mgr_last,
  output logic [11:0]         o_mgr_size,
  output logic [IDW-1:0]      o_grant_id,
  output logic                o_busy,
  output logic                o_len_err,
  output logic                o_timeout,
  output logic [1:0]          o_err_sticky
);

  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t         r_state, w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant;
  logic [11:0]    r_size;
  logic [11:0]    r_cnt;
  logic [WDW-1:0] r_wdog;
  logic           r_len_err;
  logic           r_timeout;
  logic [1:0]     r_sticky;

  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [11:0]    w_pick_size;
  logic [11:0]    w_cnt_inc;
  logic           w_xfer;
  logic           w_start;
  logic           w_skip;
  logic           w_len_evt;
  logic           w_to_evt;

  // Index arithmetic modulo N_REQ, valid for non-power-of-two counts too.
  function automatic logic [IDW-1:0] wrap_idx(input int v);
    return IDW'(v % N_REQ);
  endfunction

  // Round-robin search: first requester at or after r_ptr, wrapping.
  // Scanning downward lets the lowest offset from r_ptr win.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_ready[wrap_idx(int'(r_ptr) + i)]) begin
        w_found = 1'b1;
        w_pick  = wrap_idx(int'(r_ptr) + i);
      end
    end
  end

  assign w_pick_size = i_req_size[12*int'(w_pick) +: 12];
  assign w_cnt_inc   = r_cnt + 12'd1;
  assign w_xfer      = (r_state == S_SEND) & i_mgr_ready & i_req_ready[r_grant];

  // Next-state logic, event strobes and the combinational manager-side mux.
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that left one
    // unassigned would infer a latch.
    w_state_next    = r_state;
    w_start         = 1'b0;
    w_skip          = 1'b0;
    w_len_evt       = 1'b0;
    w_to_evt        = 1'b0;
    o_mgr_valid     = 1'b0;
    o_mgr_data      = 8'd0;
    o_mgr_last      = 1'b0;
    o_req_mgr_ready = '0;
    o_busy          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          if (w_pick_size != 12'd0) begin
            w_start      = 1'b1;
            w_state_next = S_SEND;
          end else begin
            w_skip    = 1'b1;
            w_len_evt = 1'b1;
          end
        end
      end
      S_SEND: begin
        o_busy          = 1'b1;
        o_mgr_valid     = i_req_ready[r_grant];
        o_mgr_data      = i_req_data[8*int'(r_grant) +: 8];
        o_mgr_last      = i_req_last[r_grant] & i_req_ready[r_grant];
        o_req_mgr_ready = N_REQ'(i_mgr_ready) << r_grant;
        if (w_xfer) begin
          if (i_req_last[r_grant]) begin
            w_len_evt    = (w_cnt_inc != r_size);
            w_state_next = S_GAP;
          end else begin
            // Overrun: the size is reached without a last flag.
            w_len_evt = (w_cnt_inc == r_size);
          end
        end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
          w_to_evt     = 1'b1;
          w_state_next = S_GAP;
        end
      end
      S_GAP:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state is written with <= so that every register samples
    // pre-edge values regardless of statement order.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Grant, pointer, byte counter, watchdog and error registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_size    <= '0;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_len_err <= 1'b0;
      r_timeout <= 1'b0;
      r_sticky  <= 2'b00;
    end else begin
      r_len_err <= w_len_evt;
      r_timeout <= w_to_evt;
      r_sticky  <= r_sticky | {w_to_evt, w_len_evt};
      if (w_start) begin
        r_grant <= w_pick;
        r_size  <= w_pick_size;
        r_cnt   <= '0;
        r_wdog  <= '0;
      end
      if (w_skip) r_ptr <= wrap_idx(int'(w_pick) + 1);
      if (r_state == S_SEND) begin
        if (w_xfer) begin
          r_cnt  <= w_cnt_inc;
          r_wdog <= '0;
        end else begin
          r_wdog <= r_wdog + WDW'(1);
        end
      end
      if (r_state == S_GAP) begin
        r_ptr  <= wrap_idx(int'(r_grant) + 1);
        r_size <= '0;
      end
    end
  end

  assign o_grant_id   = r_grant;
  assign o_mgr_size   = r_size;
  assign o_len_err    = r_len_err;
  assign o_timeout    = r_timeout;
  assign o_err_sticky = r_sticky;

endmodule

// File: tb/tb_task_answer_arbiter.sv
// Directed bench for task_answer_arbiter (N_REQ=4, TIMEOUT=8).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Requester k drives byte {k, b}, so the expected data also
// identifies which requester was muxed through.
module tb_task_answer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_ready, req_last, req_mgr_ready;
  logic [31:0] req_data;
  logic [47:0] req_size;
  logic        mgr_ready, mgr_valid, mgr_last, busy, len_err, timeout;
  logic [7:0]  mgr_data;
  logic [11:0] mgr_size;
  logic [1:0]  grant_id, sticky;
  logic [11:0] sizes [4];

  int n_pass = 0;
  int n_total = 0;

  task_answer_arbiter #(.N_REQ(4), .IDW(2), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_ready(req_ready), .i_req_data(req_data),
    .i_req_last(req_last), .i_req_size(req_size),
    .o_req_mgr_ready(req_mgr_ready), .i_mgr_ready(mgr_ready),
    .o_mgr_valid(mgr_valid), .o_mgr_data(mgr_data), .o_mgr_last(mgr_last),
    .o_mgr_size(mgr_size), .o_grant_id(grant_id), .o_busy(busy),
    .o_len_err(len_err), .o_timeout(timeout), .o_err_sticky(sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic       rst;
    logic [3:0] rdy, last;
    logic       mrdy;
    logic [3:0] b;
    logic       valid;
    logic [7:0] data;
    logic       mlast;
    logic [3:0] rmr;
    logic       busy;
    logic [1:0] grant;
    logic       lerr, to;
    logic [1:0] sticky;
    logic [11:0] size;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [32:0] outs();
    return {mgr_valid, mgr_data, mgr_last, req_mgr_ready, busy, grant_id,
            len_err, timeout, sticky, mgr_size};
  endfunction

  task automatic drive(input logic r, input logic [3:0] rdy, input logic [3:0] last,
                       input logic mrdy, input logic [3:0] b);
    rst       = r;
    req_ready = rdy;
    req_last  = last;
    mgr_ready = mrdy;
    for (int k = 0; k < 4; k++) begin
      req_data[8*k +: 8]  = {k[3:0], b};
      req_size[12*k +: 12] = sizes[k];
    end
  endtask

  // Advance from the sampling point to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0, 4'b0, 1'b0, 4'h0);
    @(posedge clk); @(posedge clk); #1;
  endtask

  initial begin
    // Test 1 (requester 1, size 4, manager always ready) then
    // test 3 (requester 2, size 5, manager ready toggling).
    //          rst rdy   last  mrdy b  | val data  lst rmr  bsy gnt le to stk size
    vecs[0]  = '{0, 4'h2, 4'h0, 1, 0,    0, 8'h00, 0, 4'h0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 4'h2, 4'h0, 1, 0,    1, 8'h10, 0, 4'h2, 1, 1, 0, 0, 0, 4};
    vecs[2]  = '{0, 4'h2, 4'h0, 1, 1,    1, 8'h11, 0, 4'h2, 1, 1, 0, 0, 0, 4};
    vecs[3]  = '{0, 4'h2, 4'h0, 1, 2,    1, 8'h12, 0, 4'h2, 1, 1, 0, 0, 0, 4};
    vecs[4]  = '{0, 4'h2, 4'h2, 1, 3,    1, 8'h13, 1, 4'h2, 1, 1, 0, 0, 0, 4};
    vecs[5]  = '{0, 4'h0, 4'h0, 1, 0,    0, 8'h00, 0, 4'h0, 0, 1, 0, 0, 0, 4};
    vecs[6]  = '{0, 4'h0, 4'h0, 1, 0,    0, 8'h00, 0, 4'h0, 0, 1, 0, 0, 0, 0};
    vecs[7]  = '{0, 4'h4, 4'h0, 0, 0,    0, 8'h00, 0, 4'h0, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 4'h4, 4'h0, 1, 0,    1, 8'h20, 0, 4'h4, 1, 2, 0, 0, 0, 5};
    vecs[9]  = '{0, 4'h4, 4'h0, 0, 1,    1, 8'h21, 0, 4'h0, 1, 2, 0, 0, 0, 5};
    vecs[10] = '{0, 4'h4, 4'h0, 1, 1,    1, 8'h21, 0, 4'h4, 1, 2, 0, 0, 0, 5};
    vecs[11] = '{0, 4'h4, 4'h0, 0, 2,    1, 8'h22, 0, 4'h0, 1, 2, 0, 0, 0, 5};
    vecs[12] = '{0, 4'h4, 4'h0, 1, 2,    1, 8'h22, 0, 4'h4, 1, 2, 0, 0, 0, 5};
    vecs[13] = '{0, 4'h4, 4'h0, 0, 3,    1, 8'h23, 0, 4'h0, 1, 2, 0, 0, 0, 5};
    vecs[14] = '{0, 4'h4, 4'h0, 1, 3,    1, 8'h23, 0, 4'h4, 1, 2, 0, 0, 0, 5};
    vecs[15] = '{0, 4'h4, 4'h4, 0, 4,    1, 8'h24, 1, 4'h0, 1, 2, 0, 0, 0, 5};
    vecs[16] = '{0, 4'h4, 4'h4, 1, 4,    1, 8'h24, 1, 4'h4, 1, 2, 0, 0, 0, 5};
    vecs[17] = '{0, 4'h0, 4'h0, 1, 0,    0, 8'h00, 0, 4'h0, 0, 2, 0, 0, 0, 5};
    vecs[18] = '{0, 4'h0, 4'h0, 1, 0,    0, 8'h00, 0, 4'h0, 0, 2, 0, 0, 0, 0};

    sizes = '{12'd7, 12'd4, 12'd5, 12'd7};
    do_reset();
    drive(1'b1, 4'hF, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("reset_state", outs(), 33'd0);
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].last, vecs[i].mrdy, vecs[i].b);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].valid, vecs[i].data, vecs[i].mlast, vecs[i].rmr, vecs[i].busy,
             vecs[i].grant, vecs[i].lerr, vecs[i].to, vecs[i].sticky, vecs[i].size});
      next_cycle();
    end

    // Test 2: requesters 0, 2, 3 each size 3; order 0, 2, 3, 0 with two
    // non-busy cycles (gap + idle) between packets.
    sizes = '{12'd3, 12'd3, 12'd3, 12'd3};
    do_reset();
    begin
      logic [1:0] order [4];
      order = '{2'd0, 2'd2, 2'd3, 2'd0};
      foreach (order[p]) begin
        drive(1'b0, 4'hD, 4'h0, 1'b1, 4'h0);
        @(negedge clk);
        check($sformatf("rr%0d_idle_busy", p), busy, 0);
        next_cycle();
        for (int j = 0; j < 3; j++) begin
          drive(1'b0, 4'hD, (j == 2) ? (4'h1 << order[p]) : 4'h0, 1'b1, 4'(j));
          @(negedge clk);
          check($sformatf("rr%0d_b%0d_grant", p, j), grant_id, order[p]);
          check($sformatf("rr%0d_b%0d_data", p, j), mgr_data, {2'b00, order[p], 4'(j)});
          check($sformatf("rr%0d_b%0d_busy", p, j), busy, 1);
          next_cycle();
        end
        drive(1'b0, 4'hD, 4'h0, 1'b1, 4'h0);
        @(negedge clk);
        check($sformatf("rr%0d_gap", p), {busy, mgr_valid, len_err}, 3'b000);
        next_cycle();
      end
    end

    // Test 4a: size 6, last on the 4th byte -> length error after last.
    sizes = '{12'd6, 12'd2, 12'd7, 12'd7};
    do_reset();
    drive(1'b0, 4'h1, 4'h0, 1'b1, 4'h0);
    next_cycle();
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 4'h1, (j == 3) ? 4'h1 : 4'h0, 1'b1, 4'(j));
      @(negedge clk);
      check($sformatf("short_b%0d_lerr", j), len_err, 0);
      next_cycle();
    end
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("short_gap_lerr", {len_err, sticky, busy}, 4'b1010);
    next_cycle();

    // Test 4b: size 2, last on the 4th byte -> pulse at byte 2, packet
    // continues, and the mismatched last pulses again.
    drive(1'b0, 4'h2, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("long_idle_lerr", len_err, 0);
    next_cycle();
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 4'h2, (j == 3) ? 4'h2 : 4'h0, 1'b1, 4'(j));
      @(negedge clk);
      check($sformatf("long_b%0d", j), {len_err, busy, mgr_data},
            {(j == 2) ? 1'b1 : 1'b0, 1'b1, 4'h1, 4'(j)});
      next_cycle();
    end
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("long_gap_lerr", {len_err, busy}, 2'b10);
    next_cycle();

    // Test 5: requester 3 stalls after 2 bytes -> timeout after 8 idle cycles.
    sizes = '{12'd0, 12'd3, 12'd7, 12'd5};
    do_reset();
    drive(1'b0, 4'h8, 4'h0, 1'b1, 4'h0);
    next_cycle();
    for (int j = 0; j < 2; j++) begin
      drive(1'b0, 4'h8, 4'h0, 1'b1, 4'(j));
      @(negedge clk);
      check($sformatf("wd_b%0d_data", j), mgr_data, {4'h3, 4'(j)});
      next_cycle();
    end
    for (int s = 1; s <= 8; s++) begin
      drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
      @(negedge clk);
      check($sformatf("wd_stall%0d", s), {busy, mgr_valid, req_mgr_ready, timeout},
            {1'b1, 1'b0, 4'h8, 1'b0});
      next_cycle();
    end
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("wd_gap", {timeout, sticky, busy, req_mgr_ready}, {1'b1, 2'b10, 1'b0, 4'h0});
    next_cycle();

    // Zero-size requester 0 is skipped; requester 1 is granted next.
    drive(1'b0, 4'h3, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("skip_idle", {busy, timeout, len_err}, 3'b000);
    next_cycle();
    drive(1'b0, 4'h3, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("skip_pulse", {len_err, sticky, busy}, 4'b1110);
    next_cycle();
    for (int j = 0; j < 2; j++) begin
      drive(1'b0, 4'h3, 4'h0, 1'b1, 4'(j));
      @(negedge clk);
      check($sformatf("skip_b%0d", j), {grant_id, mgr_data, mgr_size},
            {2'd1, 4'h1, 4'(j), 12'd3});
      next_cycle();
    end

    // Test 6: reset during byte 3, then clean restart from pointer 0.
    drive(1'b1, 4'h3, 4'h0, 1'b1, 4'h2);
    @(negedge clk);
    check("rst_b2_data", mgr_data, 8'h12);
    next_cycle();
    sizes[0] = 12'd2;
    drive(1'b0, 4'h3, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("after_rst_outs", outs(), 33'd0);
    next_cycle();
    drive(1'b0, 4'h3, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("restart_b0", {grant_id, mgr_data, mgr_size, busy}, {2'd0, 8'h00, 12'd2, 1'b1});
    next_cycle();
    drive(1'b0, 4'h3, 4'h1, 1'b1, 4'h1);
    @(negedge clk);
    check("restart_b1", {mgr_last, mgr_data, req_mgr_ready}, {1'b1, 8'h01, 4'h1});
    next_cycle();
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    @(negedge clk);
    check("restart_gap", {busy, len_err, sticky}, 4'b0000);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/task_answer_arbiter.md
Name: task_answer_arbiter

Overview:
- Shares the single task-manager answer interface between N_REQ task output blocks, each of which buffers one answer packet.
- Grants one requester at a time in round-robin order and forwards the manager's ready to the granted requester.
- Muxes that requester's data, last flag and packet size to the manager.
- Checks packet length and aborts stalled transfers with a watchdog.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDW, 2, grant index width, clog2(N_REQ)
TIMEOUT, 1024, idle cycles allowed in S_SEND without a byte transfer before abort (>=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_req_ready  in  N_REQ  per-requester "answer ready" (packet available / byte valid)
i_req_data  in  8*N_REQ  per-requester byte; requester k occupies [8k+7:8k]
i_req_last  in  N_REQ  per-requester last-byte flag
i_req_size  in  12*N_REQ  per-requester packet size in bytes, [12k+11:12k]
o_req_mgr_ready  out  N_REQ  forwarded manager ready; only the granted bit can be 1
i_mgr_ready  in  1  manager accepts a byte this cycle
o_mgr_valid  out  1  byte valid toward manager
o_mgr_data  out  8  byte toward manager
o_mgr_last  out  1  last byte toward manager
o_mgr_size  out  12  packet size of current grant, registered
o_grant_id  out  IDW  index of current grant, registered
o_busy  out  1  arbiter in S_SEND
o_len_err  out  1  one-cycle pulse: length mismatch or zero size
o_timeout  out  1  one-cycle pulse: watchdog abort
o_err_sticky  out  2  {timeout_seen, len_err_seen}; cleared only by reset

Behaviour:
- Reset values: state S_IDLE, rr pointer 0, o_grant_id 0, o_mgr_size 0, byte counter 0, watchdog 0. All outputs 0.
- i_rst mid-packet aborts immediately. No further o_req_mgr_ready is issued.
- S_IDLE: search i_req_ready for the first set bit, starting at index ptr and wrapping modulo N_REQ.
  - If found with size != 0: latch grant g, o_grant_id <= g, o_mgr_size <= size[g], counter <= 0, watchdog <= 0; go S_SEND.
  - If found with size == 0: pulse o_len_err, set sticky[0], ptr <= g+1 mod N_REQ; stay S_IDLE (requester skipped).
  - None found: stay.
- S_SEND, combinational from registered g:
  - o_mgr_valid = i_req_ready[g]
  - o_mgr_data = data[g]
  - o_mgr_last = i_req_last[g] & i_req_ready[g]
  - o_req_mgr_ready = i_mgr_ready << g
  - o_busy = 1
- Transfer = i_mgr_ready & i_req_ready[g]. On each transfer, counter +1 (12-bit) and watchdog <= 0; otherwise watchdog +1.
- Transfer with last:
  - If counter+1 != o_mgr_size, pulse o_len_err and set sticky[0].
  - Go S_GAP.
- Transfer without last where counter+1 == o_mgr_size: o_len_err pulse and set sticky[0] once. Continue until last or timeout.
- Watchdog reaching TIMEOUT-1 with no transfer that cycle: pulse o_timeout, set sticky[1], go S_GAP.
- S_GAP, one cycle:
  - All o_mgr_* and o_req_mgr_ready are 0; o_busy 0.
  - ptr <= g+1 mod N_REQ; o_mgr_size <= 0.
  - Go S_IDLE.
  - The gap lets the requester drop its ready after last before the next arbitration.
- Outside S_SEND: o_mgr_valid, o_mgr_data, o_mgr_last and o_req_mgr_ready are all 0.
- Latency:
  - Request to first possible transfer: 1 cycle (grant registered in S_IDLE, data passes in S_SEND).
  - Last transfer to next grant decision: 2 cycles (S_GAP, then S_IDLE).
- Requests arriving or dropping while another requester is granted are ignored until S_IDLE. No preemption.
- i_req_ready[g] dropping mid-packet is a stall, not an abort; the watchdog covers it.

Test Plan:
1. Single requester 1, size 4, manager always ready -> grant id 1 one cycle after request, 4 bytes on o_mgr_data in order, o_mgr_last on the 4th, no error pulses, S_GAP then idle.
2. Requesters 0, 2 and 3 all requesting, ptr=0, each size 3 -> grant order 0, 2, 3, then 0 again if still requesting; each packet separated by exactly 2 non-busy cycles.
3. Manager ready toggling 1,0,1,0 with size 5 -> o_req_mgr_ready[g] mirrors i_mgr_ready; counter counts only transfers; packet completes after 5 transfers, no error.
4. Size 6 but last asserted on byte 4 -> o_len_err pulses once on last transfer, sticky[0]=1. Size 2 but no last by byte 2 -> o_len_err pulses at byte 2; transfer continues to last.
5. Granted requester drops ready after 2 bytes, TIMEOUT=8 -> o_timeout pulses after 8 idle cycles, sticky=2'b10, grant moves on; i_req_size=0 request -> skipped with o_len_err pulse.
6. Assert i_rst during byte 3 of a packet -> next cycle all outputs 0, o_grant_id 0, ptr 0; arbitration restarts cleanly after reset release.
